// File: rtl/tomasulo_pkg.sv
// Shared widths, tag encoding and CDB bundle
// for the Tomasulo write-back slice.
package tomasulo_pkg;

  localparam int TAG_W    = 3;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  localparam int FU_ADD  = 0;
  localparam int FU_MUL  = 1;
  localparam int FU_LOAD = 2;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_t;

endpackage

// File: rtl/cdb_writeback_rr_arbiter.sv
// Combinational round-robin arbiter; search
// starts one past ptr and wraps.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  always_comb begin
    int   j;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 1; i <= N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_writeback.sv
// CDB arbitration, register status (Qi) table and
// register bank write pulse for the Tomasulo core.
module cdb_writeback
  import tomasulo_pkg::*;
#(
  parameter int NUM_FU = 3,
  parameter int PW     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*DATA_W-1:0] fu_data,
  output logic [NUM_FU-1:0]        fu_ack,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_rd,
  input  logic [TAG_W-1:0]         issue_tag,
  output logic [8*TAG_W-1:0]       qi_flat,
  output logic [DATA_W-1:0]        data,
  output logic [ADDR_W-1:0]        address,
  output logic                     write,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data
);

  logic [PW-1:0]     rr_q, rr_d;
  logic [TAG_W-1:0]  qi_q [NUM_REGS];
  logic [TAG_W-1:0]  qi_d [NUM_REGS];
  cdb_t              cdb_q, cdb_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [NUM_FU-1:0] gnt;
  logic [PW-1:0]     win_idx;
  logic              grant;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_data;
  logic              match;
  logic [ADDR_W-1:0] m_rd;

  rr_arbiter #(.N(NUM_FU), .PW(PW)) u_arb (
    .req (fu_valid),
    .ptr (rr_q),
    .gnt (gnt),
    .idx (win_idx)
  );

  assign grant  = |gnt;
  assign fu_ack = gnt;

  always_comb begin
    win_tag  = '0;
    win_data = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (gnt[i]) begin
        win_tag  = fu_tag[i*TAG_W +: TAG_W];
        win_data = fu_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Tag 0 would alias every ready register, so it never matches.
  always_comb begin
    match = 1'b0;
    m_rd  = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (win_tag != TAG_NONE && qi_q[r] == win_tag) begin
        match = 1'b1;
        m_rd  = ADDR_W'(r);
      end
    end
  end

  always_comb begin
    rr_d       = rr_q;
    qi_d       = qi_q;
    cdb_d      = cdb_q;
    cdb_d.valid = 1'b0;
    write_d    = 1'b0;
    addr_d     = '0;
    data_d     = data_q;
    if (grant) begin
      cdb_d.valid = 1'b1;
      cdb_d.tag   = win_tag;
      cdb_d.data  = win_data;
      rr_d        = win_idx;
      if (match) begin
        write_d    = 1'b1;
        addr_d     = m_rd;
        data_d     = win_data;
        qi_d[m_rd] = TAG_NONE;
      end
    end
    // A rename in the same cycle overrides the clear.
    if (issue_valid && issue_rd != '0)
      qi_d[issue_rd] = issue_tag;
    qi_d[0] = TAG_NONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_q    <= PW'(NUM_FU - 1);
      cdb_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      for (int r = 0; r < NUM_REGS; r++)
        qi_q[r] <= TAG_NONE;
    end else begin
      rr_q    <= rr_d;
      cdb_q   <= cdb_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      for (int r = 0; r < NUM_REGS; r++)
        qi_q[r] <= qi_d[r];
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_qi
    assign qi_flat[r*TAG_W +: TAG_W] = qi_q[r];
  end

  assign cdb_valid = cdb_q.valid;
  assign cdb_tag   = cdb_q.tag;
  assign cdb_data  = cdb_q.data;
  assign write     = write_q;
  assign address   = addr_q;
  assign data      = data_q;

endmodule

// File: tb/tb_cdb_writeback.sv
// Scoreboard bench for cdb_writeback: stimulus
// queues expected broadcasts, monitor checks them.
module tb_cdb_writeback;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  fu_valid;
  logic [8:0]  fu_tag;
  logic [47:0] fu_data;
  logic [2:0]  fu_ack;
  logic        issue_valid;
  logic [2:0]  issue_rd;
  logic [2:0]  issue_tag;
  logic [23:0] qi_flat;
  logic [15:0] data;
  logic [2:0]  address;
  logic        write;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;

  typedef struct {
    logic [2:0]  tag;
    logic [15:0] cdata;
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] bdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  cdb_writeback dut (
    .clock       (clock),
    .reset       (reset),
    .fu_valid    (fu_valid),
    .fu_tag      (fu_tag),
    .fu_data     (fu_data),
    .fu_ack      (fu_ack),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_tag   (issue_tag),
    .qi_flat     (qi_flat),
    .data        (data),
    .address     (address),
    .write       (write),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data)
  );

  function automatic logic [2:0] qi(int r);
    return qi_flat[r*3 +: 3];
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(logic [2:0] t, logic [15:0] cd, logic w,
                      logic [2:0] a, logic [15:0] bd);
    exp_t e;
    e.tag = t; e.cdata = cd; e.wr = w; e.addr = a; e.bdata = bd;
    exp_q.push_back(e);
  endtask

  task automatic issue(logic [2:0] rd, logic [2:0] t);
    issue_valid = 1'b1;
    issue_rd    = rd;
    issue_tag   = t;
    step();
    issue_valid = 1'b0;
  endtask

  task automatic set_fu(int i, logic [2:0] t, logic [15:0] d);
    fu_tag[i*3 +: 3]   = t;
    fu_data[i*16 +: 16] = d;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (cdb_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL cdb_unexpected: tag %0d data %h", cdb_tag, cdb_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (cdb_tag !== e.tag || cdb_data !== e.cdata ||
              write !== e.wr || address !== e.addr || data !== e.bdata) begin
            n_bad++;
            $display("FAIL cdb_beat: got tag %0d cd %h wr %b a %0d bd %h expected tag %0d cd %h wr %b a %0d bd %h",
                     cdb_tag, cdb_data, write, address, data,
                     e.tag, e.cdata, e.wr, e.addr, e.bdata);
          end
        end
      end else begin
        chk("idle_write", {31'd0, write}, 32'd0);
      end
    end
  end

  initial begin
    reset       = 1'b1;
    fu_valid    = '0;
    fu_tag      = '0;
    fu_data     = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    issue_tag   = '0;
    step();
    step();
    chk("rst_write", {31'd0, write}, 32'd0);
    chk("rst_cdb_valid", {31'd0, cdb_valid}, 32'd0);
    chk("rst_qi", {8'd0, qi_flat}, 32'd0);
    chk("rst_cdb_tag", {29'd0, cdb_tag}, 32'd0);
    chk("rst_cdb_data", {16'd0, cdb_data}, 32'd0);
    chk("rst_data_addr", {13'd0, data, address}, 32'd0);
    reset = 1'b0;
    step();

    issue(3'd3, 3'd2);
    chk("qi3_issue", {29'd0, qi(3)}, 32'd2);
    chk("qi0_zero", {29'd0, qi(0)}, 32'd0);
    step();

    fu_valid = 3'b001;
    set_fu(0, 3'd2, 16'h00A5);
    #1;
    chk("ack_single", {29'd0, fu_ack}, 32'b001);
    push(3'd2, 16'h00A5, 1'b1, 3'd3, 16'h00A5);
    step();
    fu_valid = '0;
    chk("qi3_cleared", {29'd0, qi(3)}, 32'd0);
    step();

    issue(3'd4, 3'd1);
    issue(3'd4, 3'd5);
    fu_valid = 3'b010;
    set_fu(1, 3'd1, 16'h0007);
    #1;
    chk("ack_stale", {29'd0, fu_ack}, 32'b010);
    push(3'd1, 16'h0007, 1'b0, 3'd0, 16'h00A5);
    step();
    chk("qi4_kept", {29'd0, qi(4)}, 32'd5);
    set_fu(1, 3'd5, 16'h0009);
    #1;
    chk("ack_fresh", {29'd0, fu_ack}, 32'b010);
    push(3'd5, 16'h0009, 1'b1, 3'd4, 16'h0009);
    step();
    fu_valid = '0;
    chk("qi4_cleared", {29'd0, qi(4)}, 32'd0);
    step();

    issue(3'd6, 3'd3);
    fu_valid    = 3'b100;
    set_fu(2, 3'd3, 16'h1234);
    issue_valid = 1'b1;
    issue_rd    = 3'd6;
    issue_tag   = 3'd4;
    #1;
    chk("ack_collide", {29'd0, fu_ack}, 32'b100);
    push(3'd3, 16'h1234, 1'b1, 3'd6, 16'h1234);
    step();
    fu_valid    = '0;
    issue_valid = 1'b0;
    chk("qi6_issue_wins", {29'd0, qi(6)}, 32'd4);
    step();

    issue(3'd1, 3'd1);
    issue(3'd2, 3'd2);
    issue(3'd5, 3'd5);
    set_fu(0, 3'd1, 16'h0011);
    set_fu(1, 3'd2, 16'h0022);
    set_fu(2, 3'd5, 16'h0033);
    fu_valid = 3'b111;
    #1;
    chk("ack_rr0", {29'd0, fu_ack}, 32'b001);
    push(3'd1, 16'h0011, 1'b1, 3'd1, 16'h0011);
    step();
    fu_valid = 3'b110;
    #1;
    chk("ack_rr1", {29'd0, fu_ack}, 32'b010);
    push(3'd2, 16'h0022, 1'b1, 3'd2, 16'h0022);
    step();
    fu_valid = 3'b100;
    #1;
    chk("ack_rr2", {29'd0, fu_ack}, 32'b100);
    push(3'd5, 16'h0033, 1'b1, 3'd5, 16'h0033);
    step();
    fu_valid = '0;
    chk("qi_rr_cleared", {29'd0, qi(1) | qi(2) | qi(5)}, 32'd0);
    step();

    fu_valid = 3'b001;
    set_fu(0, 3'd0, 16'h0055);
    #1;
    chk("ack_tag0", {29'd0, fu_ack}, 32'b001);
    push(3'd0, 16'h0055, 1'b0, 3'd0, 16'h0033);
    step();
    fu_valid = '0;
    step();

    issue(3'd7, 3'd6);
    fu_valid = 3'b010;
    set_fu(1, 3'd6, 16'hBEEF);
    #1;
    chk("ack_pre_rst", {29'd0, fu_ack}, 32'b010);
    step();
    fu_valid = '0;
    chk("write_pre_rst", {31'd0, write}, 32'd1);
    chk("qi6_pre_rst", {29'd0, qi(6)}, 32'd4);
    #1;
    reset = 1'b1;
    #1;
    chk("async_write", {31'd0, write}, 32'd0);
    chk("async_cdb_valid", {31'd0, cdb_valid}, 32'd0);
    chk("async_qi", {8'd0, qi_flat}, 32'd0);
    step();
    reset = 1'b0;
    issue(3'd0, 3'd7);
    chk("rd0_ignored", {8'd0, qi_flat}, 32'd0);
    step();
    step();

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cdb_writeback.md
Name: cdb_writeback

Overview:
- Write-back end of the Tomasulo register bank's write interface (data/address/write).
- Arbitrates completed results from the functional units onto the Common Data Bus (CDB).
- Maintains the register status table (Qi: producing tag per register).
- Drives a single-cycle write pulse into the bank only when the broadcast tag is still the latest producer of that register.

Parameters:
NUM_FU, 3, number of functional-unit result sources (add, mul, load)
TAG_W, 3, reservation-station tag width; tag 0 = "no producer"
DATA_W, 16, result/register data width
ADDR_W, 3, register address width; registers 1..7 are writable, address 0 means none

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
fu_valid  in  NUM_FU  result pending from FU i; held until acked
fu_tag  in  NUM_FU*TAG_W  tag of FU i result, packed, FU0 in LSBs
fu_data  in  NUM_FU*DATA_W  result of FU i, packed, FU0 in LSBs
fu_ack  out  NUM_FU  one-hot grant, combinational, same cycle as capture
issue_valid  in  1  issue stage renames a destination this cycle
issue_rd  in  ADDR_W  destination register of the issued instruction
issue_tag  in  TAG_W  tag of the reservation station allocated
qi_flat  out  8*TAG_W  Qi table, entry r at bits [r*TAG_W +: TAG_W]; entry 0 always 0
data  out  DATA_W  register bank write data
address  out  ADDR_W  register bank write address
write  out  1  register bank write enable, one-cycle pulse
cdb_valid  out  1  CDB broadcast valid
cdb_tag  out  TAG_W  CDB broadcast tag
cdb_data  out  DATA_W  CDB broadcast data

Behaviour:
- Reset (async): all Qi = 0; rr_ptr = NUM_FU-1; data, address, cdb_tag, cdb_data = 0; write = 0; cdb_valid = 0.
- Arbitration (combinational):
  - Round-robin over fu_valid, searching from rr_ptr+1 with wrap.
  - fu_ack is one-hot on the winner; all zero if no fu_valid.
  - The FU drops or advances its result on the cycle after it sees ack.
- Capture, at the rising edge with a grant:
  - cdb_valid = 1; cdb_tag and cdb_data = winner's tag and data.
  - rr_ptr = winner index.
- Without a grant: cdb_valid = 0; cdb_tag and cdb_data hold their values.
- Latency: one cycle from fu_ack to CDB and bank outputs. Throughput: one result per cycle.
- Register match (combinational on the winner's tag): find r in 1..7 with Qi[r] == tag.
  - At most one match is possible, because renaming overwrites Qi.
  - On a match, at the edge: write = 1, address = r, data = winner's data, Qi[r] = 0.
  - No match (superseded by a later rename, or tag 0): write = 0, address = 0, data unchanged. The result is still broadcast on the CDB.
- write deasserts the next cycle unless a new matching grant occurs.
- Issue, at the edge when issue_valid: Qi[issue_rd] = issue_tag.
  - issue_rd = 0 is ignored.
  - issue_tag = 0 is legal and marks the register ready.
- Simultaneous events:
  - Issue to r while the CDB clears r: issue wins, so Qi[r] = issue_tag. The bank write for the old tag still occurs that cycle.
  - Issue renames r with the same tag currently winning: Qi[r] = issue_tag (issue wins); the write still occurs.
- Grant with tag 0: broadcast with cdb_tag = 0, no bank write.
- Reset mid-operation: outputs and Qi clear immediately; any pending ack is lost. FUs must re-present results after reset.
- qi_flat reflects registered Qi state: updates appear one cycle after issue or clear.

Decomposition:
- Shared package tomasulo_pkg holds:
  - TAG_W, DATA_W, ADDR_W, NUM_REGS = 8
  - TAG_NONE = 0
  - FU index constants FU_ADD = 0, FU_MUL = 1, FU_LOAD = 2
  - typedef cdb_t {valid, tag, data}
- One sub-module, rr_arbiter: NUM_FU-wide round-robin.
  - Inputs: req, pointer.
  - Outputs: one-hot grant, encoded index.
  - Purely combinational; the pointer register lives in cdb_writeback.

Test Plan:
- Reset then idle: issue_valid=1 rd=3 tag=2; next cycle qi_flat entry3=2; no fu_valid -> write=0, cdb_valid=0 throughout.
- Single result: Qi[3]=2; fu_valid[0]=1 tag=2 data=16'h00A5 -> fu_ack=3'b001 same cycle; next cycle write=1 address=3 data=16'h00A5, cdb_valid=1 cdb_tag=2; Qi[3]=0; following cycle write=0.
- Superseded rename: issue rd=4 tag=1, then rd=4 tag=5; FU1 returns tag=1 data=7 -> cdb_valid=1 cdb_tag=1, write=0, Qi[4] stays 5; FU returns tag=5 data=9 -> write=1 address=4 data=9.
- Round-robin fairness: all three fu_valid held high with distinct tags mapped to R1, R2, R5 -> acks 001, 010, 100 on consecutive cycles; bank writes to addresses 1, 2, 5 in that order.
- Issue/clear collision: Qi[6]=3; same cycle FU2 wins with tag=3 data=16'h1234 and issue rd=6 tag=4 -> write=1 address=6 data=16'h1234; Qi[6]=4 afterward.
- Async reset mid-burst: assert reset between clock edges while write=1 -> write, cdb_valid and all Qi go to 0 immediately without waiting for a clock edge; issue_rd=0 with issue_valid=1 leaves qi_flat entry0=0.
